compute_plain_broadcast_dsplit: RTL
===================================

Name: compute_plain_broadcast_dsplit

Overview:
Computes the SDitH plain broadcast values for T challenge points, generalised to D_SPLIT polynomial splits: alpha_j = a_j + sum_d eps_{j,d}*Q_d(r_j) and beta_j = b_j + sum_d S_d(r_j).
- Sits in the sign datapath between the Q/S share memories and the shared evaluate / GF32 multiplier engines.
- GF(2^32) addition is XOR and is done internally, so the block has no external GF32 adder port.
- With D_SPLIT=1 it is functionally the single-split broadcast.

Parameters:
- T, 3, number of challenge points (32-bit lanes).
- D_SPLIT, 2, number of polynomial splits accumulated.
- POLY_LEN, 176, coefficients per split polynomial (bytes).
- ADDR_W, `CLOG2(D_SPLIT*POLY_LEN), share memory address width.

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_start, in, 1, start pulse; sampled only in IDLE.
- o_busy, out, 1, high from the cycle after an accepted start until o_done.
- o_done, out, 1, one-cycle completion pulse.
- i_q, in, 8, Q share byte.
- o_q_addr, out, ADDR_W, Q address.
- o_q_rd, out, 1, Q read strobe.
- i_s, in, 8, S share byte.
- o_s_addr, out, ADDR_W, S address.
- o_s_rd, out, 1, S read strobe.
- i_r, in, 32*T, evaluation points.
- i_eps, in, 32*T*D_SPLIT, eps; split d at bits [32*T*(d+1)-1 : 32*T*d].
- i_a, in, 32*T, a shares.
- i_b, in, 32*T, b shares.
- o_alpha, out, 32*T, alpha result; lane j at [32j+31:32j].
- o_beta, out, 32*T, beta result.
- o_start_evaluate, out, 1, evaluate start pulse.
- o_q_s, out, 8, byte routed to the evaluator.
- i_q_s_addr, in, `CLOG2(POLY_LEN), evaluator local address.
- i_q_s_rd, in, 1, evaluator read strobe.
- o_r_eps, out, 32*T, points to the evaluator (= i_r).
- i_evaluate_out, in, 32*T, evaluation result.
- i_done_evaluate, in, 1, evaluator done pulse.
- o_start_mul32, out, 1, multiplier start pulse.
- o_x_mul32, out, 32, multiplier operand x.
- o_y_mul32, out, 32, multiplier operand y.
- i_o_mul32, in, 32, product.
- i_done_mul32, in, 1, product valid pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; split counter d=0; lane counter j=0; accumulators cleared.
- Address generation: o_q_addr = o_s_addr = d*POLY_LEN + i_q_s_addr, registered-free (combinational). o_q_rd = o_s_rd = i_q_s_rd.
- Data routing: o_q_s = i_q in Q phases, i_s in S phases.
- States and transitions:
  - IDLE: on i_start, clear acc_alpha/acc_beta, set d=0, go to Q_START.
  - Q_START: o_start_evaluate=1 for one cycle, o_q_s=i_q, go to Q_WAIT.
  - Q_WAIT: on i_done_evaluate, latch i_evaluate_out into ev_reg, set j=0, go to MUL_ISSUE.
  - MUL_ISSUE: o_start_mul32=1 for one cycle with x=ev_reg lane j and y=eps_{j,d}; go to MUL_WAIT.
  - MUL_WAIT: on i_done_mul32, acc_alpha lane j ^= i_o_mul32. If j==T-1 go to S_START, else j++ and return to MUL_ISSUE. The multiplier has exactly one request outstanding at a time.
  - S_START: one-cycle evaluate start with o_q_s=i_s, go to S_WAIT.
  - S_WAIT: on i_done_evaluate, acc_beta ^= i_evaluate_out. If d==D_SPLIT-1 go to FINAL, else d++ and go to Q_START.
  - FINAL: o_alpha <= acc_alpha ^ i_a; o_beta <= acc_beta ^ i_b; go to DONE.
  - DONE: o_done=1 for one cycle, go to IDLE.
- o_alpha/o_beta hold their values until the next FINAL or reset.
- Latency: D_SPLIT*(2*(Le+1) + T*(Lm+1)) + 2 cycles from the accepted start to o_done, where Le = evaluator start-to-done and Lm = multiplier start-to-done.
- Boundary and error conditions:
  - i_start outside IDLE is ignored.
  - i_done_evaluate outside Q_WAIT/S_WAIT is ignored, as is i_done_mul32 outside MUL_WAIT.
  - A done pulse in the same cycle as the corresponding start is not accepted.
  - i_r, i_eps, i_a and i_b must stay stable while o_busy is high.
  - Reset mid-operation returns to IDLE next cycle, deasserts every start strobe and o_busy, and clears the outputs.
  - D_SPLIT=1 or T=1 must elaborate; counter widths are max(1, `CLOG2(x)).

Decomposition:
- Shared sdith_pkg holds the per-PARAMETER_SET constants T, D_SPLIT, POLY_LEN and the state encoding localparams.
- One natural sub-module: pb_lane_acc, a T-lane 32-bit XOR accumulator with a lane-select write, a full-vector XOR write and clear.
- The FSM and address offset logic stay in the top level.

Test Plan:
- Single split: D_SPLIT=1, T=3, mock evaluator returns {3,2,1} for Q and {0x30,0x20,0x10} for S, eps=1, a={0xA,0xB,0xC}, b=0 -> o_alpha={3^0xA,2^0xB,1^0xC}, o_beta={0x30,0x20,0x10}, one o_done pulse.
- Two splits: D_SPLIT=2 with a GF(2^32) reference-model multiplier, random eps/r/a/b -> o_alpha/o_beta match the golden model; o_q_addr covers 0..175 then 176..351.
- Multiplier stall: vary Lm between 1 and 20 cycles -> exactly T*D_SPLIT o_start_mul32 pulses, never two outstanding, same results.
- Protocol robustness: i_start pulsed while busy and spurious i_done_mul32 in Q_WAIT -> ignored; results and cycle count unchanged.
- Reset mid-MUL_WAIT: assert i_rst for 1 cycle -> o_busy=0, o_alpha=0, no start strobes; a fresh i_start then completes correctly.
- Zero eps: eps=0, a=b=0 -> o_alpha=0 and o_beta = XOR of the S evaluations.

Source files
------------

// File: rtl/compute_plain_broadcast_dsplit_pkg.sv
// Shared constants and FSM encoding for the SDitH plain-broadcast block.
package compute_plain_broadcast_dsplit_pkg;

    localparam int PB_T        = 3;
    localparam int PB_D_SPLIT  = 2;
    localparam int PB_POLY_LEN = 176;

    // Counter width that stays legal when the count is 1.
    function automatic int cw(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_Q_START,
        ST_Q_WAIT,
        ST_MUL_ISSUE,
        ST_MUL_WAIT,
        ST_S_START,
        ST_S_WAIT,
        ST_FINAL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/compute_plain_broadcast_dsplit_if.sv
// Share-memory, evaluator and GF32 multiplier engine bus of the broadcast block.
interface compute_plain_broadcast_dsplit_if #(
    parameter int T       = 3,
    parameter int ADDR_W  = 9,
    parameter int LADDR_W = 8
);
    logic [7:0]        i_q;
    logic [ADDR_W-1:0] o_q_addr;
    logic              o_q_rd;
    logic [7:0]        i_s;
    logic [ADDR_W-1:0] o_s_addr;
    logic              o_s_rd;
    logic              o_start_evaluate;
    logic [7:0]        o_q_s;
    logic [LADDR_W-1:0] i_q_s_addr;
    logic              i_q_s_rd;
    logic [32*T-1:0]   o_r_eps;
    logic [32*T-1:0]   i_evaluate_out;
    logic              i_done_evaluate;
    logic              o_start_mul32;
    logic [31:0]       o_x_mul32;
    logic [31:0]       o_y_mul32;
    logic [31:0]       i_o_mul32;
    logic              i_done_mul32;

    modport master (
        input  i_q, i_s, i_q_s_addr, i_q_s_rd, i_evaluate_out, i_done_evaluate,
               i_o_mul32, i_done_mul32,
        output o_q_addr, o_q_rd, o_s_addr, o_s_rd, o_start_evaluate, o_q_s,
               o_r_eps, o_start_mul32, o_x_mul32, o_y_mul32
    );

    modport slave (
        output i_q, i_s, i_q_s_addr, i_q_s_rd, i_evaluate_out, i_done_evaluate,
               i_o_mul32, i_done_mul32,
        input  o_q_addr, o_q_rd, o_s_addr, o_s_rd, o_start_evaluate, o_q_s,
               o_r_eps, o_start_mul32, o_x_mul32, o_y_mul32
    );
endinterface

// File: rtl/compute_plain_broadcast_dsplit_pb_lane_acc.sv
// T-lane 32-bit GF(2^32) accumulator: single-lane XOR, full-vector XOR, clear.
module pb_lane_acc #(
    parameter int T     = 3,
    parameter int SEL_W = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_lane_we,
    input  logic [SEL_W-1:0]     i_lane_sel,
    input  logic [31:0]          i_lane_data,
    input  logic                 i_vec_we,
    input  logic [T-1:0][31:0]   i_vec_data,
    output logic [T-1:0][31:0]   o_acc
);
    logic [T-1:0][31:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        for (int l = 0; l < T; l++) begin
            if (i_lane_we && i_lane_sel == SEL_W'(l))
                acc_d[l] = acc_d[l] ^ i_lane_data;
            if (i_vec_we)
                acc_d[l] = acc_d[l] ^ i_vec_data[l];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) acc_q <= '0;
        else                acc_q <= acc_d;
    end

    assign o_acc = acc_q;
endmodule

// File: rtl/compute_plain_broadcast_dsplit.sv
// alpha_j = a_j ^ sum_d eps_{j,d}*Q_d(r_j), beta_j = b_j ^ sum_d S_d(r_j), using shared engines.
module compute_plain_broadcast_dsplit
    import compute_plain_broadcast_dsplit_pkg::*;
#(
    parameter int T        = PB_T,
    parameter int D_SPLIT  = PB_D_SPLIT,
    parameter int POLY_LEN = PB_POLY_LEN,
    parameter int ADDR_W   = $clog2(D_SPLIT*POLY_LEN)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    input  logic [32*T-1:0]         i_r,
    input  logic [32*T*D_SPLIT-1:0] i_eps,
    input  logic [32*T-1:0]         i_a,
    input  logic [32*T-1:0]         i_b,
    output logic [32*T-1:0]         o_alpha,
    output logic [32*T-1:0]         o_beta,
    compute_plain_broadcast_dsplit_if.master eng
);
    localparam int JW = cw(T);
    localparam int DW = cw(D_SPLIT);

    state_e state_q, state_d;
    logic [JW-1:0] j_q, j_d;
    logic [DW-1:0] d_q, d_d;
    logic [T-1:0][31:0] ev_q, acc_alpha, acc_beta, alpha_q, beta_q;
    logic [D_SPLIT-1:0][T-1:0][31:0] eps_w;
    logic acc_clr, ev_we, fin;
    logic ev_hit, mul_hit;

    assign eps_w   = i_eps;
    assign ev_hit  = eng.i_done_evaluate &&
                     (state_q == ST_Q_WAIT || state_q == ST_S_WAIT);
    assign mul_hit = eng.i_done_mul32 && state_q == ST_MUL_WAIT;

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        j_d     = j_q;
        acc_clr = 1'b0;
        ev_we   = 1'b0;
        fin     = 1'b0;
        case (state_q)
            ST_IDLE: if (i_start) begin
                acc_clr = 1'b1;
                d_d     = '0;
                state_d = ST_Q_START;
            end
            ST_Q_START: state_d = ST_Q_WAIT;
            ST_Q_WAIT: if (ev_hit) begin
                ev_we   = 1'b1;
                j_d     = '0;
                state_d = ST_MUL_ISSUE;
            end
            ST_MUL_ISSUE: state_d = ST_MUL_WAIT;
            ST_MUL_WAIT: if (mul_hit) begin
                if (j_q == JW'(T-1)) state_d = ST_S_START;
                else begin
                    j_d     = j_q + JW'(1);
                    state_d = ST_MUL_ISSUE;
                end
            end
            ST_S_START: state_d = ST_S_WAIT;
            ST_S_WAIT: if (ev_hit) begin
                if (d_q == DW'(D_SPLIT-1)) state_d = ST_FINAL;
                else begin
                    d_d     = d_q + DW'(1);
                    state_d = ST_Q_START;
                end
            end
            ST_FINAL: begin
                fin     = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            j_q     <= '0;
            ev_q    <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            j_q     <= j_d;
            if (ev_we) ev_q <= eng.i_evaluate_out;
            if (fin) begin
                alpha_q <= acc_alpha ^ i_a;
                beta_q  <= acc_beta ^ i_b;
            end
        end
    end

    pb_lane_acc #(.T(T), .SEL_W(JW)) u_acc_alpha (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(acc_clr),
        .i_lane_we(mul_hit), .i_lane_sel(j_q), .i_lane_data(eng.i_o_mul32),
        .i_vec_we(1'b0), .i_vec_data('0), .o_acc(acc_alpha)
    );

    pb_lane_acc #(.T(T), .SEL_W(JW)) u_acc_beta (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(acc_clr),
        .i_lane_we(1'b0), .i_lane_sel('0), .i_lane_data('0),
        .i_vec_we(ev_hit && state_q == ST_S_WAIT), .i_vec_data(eng.i_evaluate_out),
        .o_acc(acc_beta)
    );

    // Split d owns the address window [d*POLY_LEN, (d+1)*POLY_LEN).
    assign eng.o_q_addr = ADDR_W'(d_q) * ADDR_W'(POLY_LEN) + ADDR_W'(eng.i_q_s_addr);
    assign eng.o_s_addr = eng.o_q_addr;
    assign eng.o_q_rd   = eng.i_q_s_rd;
    assign eng.o_s_rd   = eng.i_q_s_rd;
    assign eng.o_r_eps  = i_r;

    always_comb begin
        eng.o_q_s = 8'h00;
        case (state_q)
            ST_Q_START, ST_Q_WAIT: eng.o_q_s = eng.i_q;
            ST_S_START, ST_S_WAIT: eng.o_q_s = eng.i_s;
            default:               eng.o_q_s = 8'h00;
        endcase
    end

    assign eng.o_start_evaluate = (state_q == ST_Q_START) || (state_q == ST_S_START);
    assign eng.o_start_mul32    = (state_q == ST_MUL_ISSUE);
    assign eng.o_x_mul32        = (state_q == ST_MUL_ISSUE) ? ev_q[j_q] : 32'h0;
    assign eng.o_y_mul32        = (state_q == ST_MUL_ISSUE) ? eps_w[d_q][j_q] : 32'h0;

    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = (state_q == ST_DONE);
    assign o_alpha = alpha_q;
    assign o_beta  = beta_q;
endmodule
